// File: rtl/fp32_adder_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor.
// Accepts op1/op2 on a ready request and pulses done when res holds the
// round-to-nearest-even sum. Subnormals, zeros, infinities and NaN are handled.
//
// Handshake: ready is a start request sampled only in ST_IDLE. op1, op2 and sub
// are read in the cycle after that sample (ST_INIT), so the producer holds them
// stable until then. done is a one-cycle pulse. res is valid from that cycle
// onward and holds until the next result is written.
module fp32_adder_seq #(
    parameter int MAX_ALIGN = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic        sub,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        done
);

    localparam logic [7:0] MAX_ALIGN_D = MAX_ALIGN[7:0];

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_NAN,
        ST_INF,
        ST_ZERO,
        ST_SWAP,
        ST_ALIGN,
        ST_ADD,
        ST_ZERO_EXACT,
        ST_NORMR,
        ST_NORML,
        ST_ROUND,
        ST_OVF,
        ST_WRITE,
        ST_FINISH
    } state_t;

    // Current FSM state. Kept as a named enum so checkers can bind to it.
    state_t state;

    logic [31:0] op_a;       // op1 as latched
    logic [31:0] op_b;       // op2 as latched (raw sign)
    logic        sb;         // effective sign of op2 (sign ^ sub)
    logic        sign_r;     // sign of the larger-magnitude operand
    logic        eff_sub;    // operand signs differ: subtract magnitudes
    logic [7:0]  exp_a;      // exponent of the larger operand
    logic [7:0]  d;          // remaining alignment distance
    logic [26:0] m_a;        // {mant, G, R, S} of the larger operand
    logic [26:0] m_b;        // {mant, G, R, S} of the smaller operand
    logic [27:0] m;          // working result mantissa, bit27 = carry
    logic [9:0]  e;          // working result exponent
    logic        rnd_carry;  // rounding carried into bit27; renormalise next

    function automatic logic f_is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    function automatic logic f_is_inf(input logic [31:0] x);
        return (&x[30:23]) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic f_is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_big;
    logic [27:0] add_sum;
    logic        rnd_inc;
    logic [27:0] rnd_sum;
    logic [9:0]  e_inc;

    // Operand unpacking, magnitude ordering, add/sub and rounding increment
    always_comb begin
        ea      = (op_a[30:23] == 8'd0) ? 8'd1 : op_a[30:23];
        eb      = (op_b[30:23] == 8'd0) ? 8'd1 : op_b[30:23];
        ma      = {op_a[30:23] != 8'd0, op_a[22:0]};
        mb      = {op_b[30:23] != 8'd0, op_b[22:0]};
        a_big   = {ea, ma} >= {eb, mb};
        add_sum = eff_sub ? ({1'b0, m_a} - {1'b0, m_b})
                          : ({1'b0, m_a} + {1'b0, m_b});
        rnd_inc = m[2] & (m[1] | m[0] | m[3]);
        rnd_sum = m + {24'd0, rnd_inc, 3'd0};
        e_inc   = e + 10'd1;
    end

    // Control FSM and datapath registers, including the registered res/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            res       <= 32'd0;
            done      <= 1'b0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            sb        <= 1'b0;
            sign_r    <= 1'b0;
            eff_sub   <= 1'b0;
            exp_a     <= 8'd0;
            d         <= 8'd0;
            m_a       <= 27'd0;
            m_b       <= 27'd0;
            m         <= 28'd0;
            e         <= 10'd0;
            rnd_carry <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ready) state <= ST_INIT;
                end
                ST_INIT: begin
                    op_a <= op1;
                    op_b <= op2;
                    sb   <= op2[31] ^ sub;
                    if (f_is_nan(op1) || f_is_nan(op2))
                        state <= ST_NAN;
                    else if (f_is_inf(op1) || f_is_inf(op2))
                        state <= ST_INF;
                    else if (f_is_zero(op1) && f_is_zero(op2))
                        state <= ST_ZERO;
                    else
                        state <= ST_SWAP;
                end
                ST_NAN: begin
                    res   <= f_is_nan(op_a) ? (op_a | 32'h0040_0000)
                                            : (op_b | 32'h0040_0000);
                    done  <= 1'b1;
                    state <= ST_FINISH;
                end
                ST_INF: begin
                    if (f_is_inf(op_a) && f_is_inf(op_b) && (op_a[31] != sb))
                        res <= 32'hFFC0_0000;
                    else if (f_is_inf(op_a))
                        res <= op_a;
                    else
                        res <= {sb, op_b[30:0]};
                    done  <= 1'b1;
                    state <= ST_FINISH;
                end
                ST_ZERO: begin
                    res   <= {op_a[31] & sb, 31'd0};
                    done  <= 1'b1;
                    state <= ST_FINISH;
                end
                ST_SWAP: begin
                    eff_sub <= op_a[31] ^ sb;
                    if (a_big) begin
                        m_a    <= {ma, 3'b000};
                        m_b    <= {mb, 3'b000};
                        exp_a  <= ea;
                        d      <= ea - eb;
                        sign_r <= op_a[31];
                    end else begin
                        m_a    <= {mb, 3'b000};
                        m_b    <= {ma, 3'b000};
                        exp_a  <= eb;
                        d      <= eb - ea;
                        sign_r <= sb;
                    end
                    // Equal exponents need no alignment cycle
                    state <= (ea == eb) ? ST_ADD : ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (d >= MAX_ALIGN_D) begin
                        m_b   <= {26'd0, |m_b};
                        d     <= 8'd0;
                        state <= ST_ADD;
                    end else begin
                        m_b <= {1'b0, m_b[26:2], m_b[1] | m_b[0]};
                        d   <= d - 8'd1;
                        if (d == 8'd1) state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    m         <= add_sum;
                    e         <= {2'b00, exp_a};
                    rnd_carry <= 1'b0;
                    if (add_sum == 28'd0)
                        state <= ST_ZERO_EXACT;
                    else if (add_sum[27])
                        state <= ST_NORMR;
                    else if (!add_sum[26] && (exp_a > 8'd1))
                        state <= ST_NORML;
                    else
                        state <= ST_ROUND;
                end
                ST_ZERO_EXACT: begin
                    res   <= 32'd0;
                    done  <= 1'b1;
                    state <= ST_FINISH;
                end
                ST_NORMR: begin
                    m     <= {1'b0, m[27:2], m[1] | m[0]};
                    e     <= e_inc;
                    state <= ST_ROUND;
                end
                ST_NORML: begin
                    m <= {m[26:0], 1'b0};
                    e <= e - 10'd1;
                    // Stop once normalised, or at exponent 1 (subnormal result)
                    if (m[25] || (e == 10'd2)) state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (rnd_carry) begin
                        m         <= {1'b0, m[27:1]};
                        e         <= e_inc;
                        rnd_carry <= 1'b0;
                        state     <= (e_inc >= 10'd255) ? ST_OVF : ST_WRITE;
                    end else begin
                        m <= rnd_sum;
                        if (rnd_sum[27])
                            rnd_carry <= 1'b1;
                        else
                            state <= (e >= 10'd255) ? ST_OVF : ST_WRITE;
                    end
                end
                ST_OVF: begin
                    res   <= {sign_r, 8'hFF, 23'd0};
                    done  <= 1'b1;
                    state <= ST_FINISH;
                end
                ST_WRITE: begin
                    // bit26 clear means a subnormal: exponent field is zero
                    res   <= {sign_r, (m[26] ? e[7:0] : 8'd0), m[25:3]};
                    done  <= 1'b1;
                    state <= ST_FINISH;
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_adder_seq.sv
// Self-checking bench for fp32_adder_seq: directed corner cases, an abort by
// reset mid-alignment, then randomized operands checked against an exact
// wide-integer reference model with round-to-nearest-even.
module tb_fp32_adder_seq;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        sub;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic        done;

    int checks;
    int passes;
    int cyc;
    int start_cyc;
    int done_cnt;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    logic        prev_done;
    logic [31:0] held_res;

    fp32_adder_seq #(.MAX_ALIGN(26)) dut (
        .clk  (clk),
        .rst  (rst),
        .ready(ready),
        .sub  (sub),
        .op1  (op1),
        .op2  (op2),
        .res  (res),
        .done (done)
    );

    // clock / reset / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    // reference model
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // exact magnitude in units of 2^-149
    function automatic logic [287:0] mag_of(input logic [31:0] x);
        int          ex;
        logic [23:0] mn;
        ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        mn = {x[30:23] != 8'd0, x[22:0]};
        return 288'(mn) << (ex - 1);
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic           sa, sbe, sr;
        logic [287:0]   ma, mb, mag, q, rem, half;
        int             p, sh;
        sa  = a[31];
        sbe = b[31] ^ s;
        if (is_nan(a)) return a | 32'h0040_0000;
        if (is_nan(b)) return b | 32'h0040_0000;
        if (is_inf(a) && is_inf(b) && (sa != sbe)) return 32'hFFC0_0000;
        if (is_inf(a)) return a;
        if (is_inf(b)) return {sbe, b[30:0]};
        ma = mag_of(a);
        mb = mag_of(b);
        if (sa == sbe) begin mag = ma + mb; sr = sa; end
        else if (ma >= mb) begin mag = ma - mb; sr = sa; end
        else begin mag = mb - ma; sr = sbe; end
        if (mag == 288'd0)
            return {((ma == 288'd0) && (mb == 288'd0)) ? (sa & sbe) : 1'b0, 31'd0};
        p = 0;
        for (int i = 0; i < 288; i++) if (mag[i]) p = i;
        // below 2^24 units the value is exact and its encoding is the integer
        if (p < 24) return {sr, mag[30:0]};
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 288'd1 << (sh - 1);
        if ((rem > half) || ((rem == half) && q[0])) q = q + 288'd1;
        if (q[24]) begin q = q >> 1; sh++; end
        if (sh + 1 >= 255) return {sr, 8'hFF, 23'd0};
        return {sr, 8'(sh + 1), q[22:0]};
    endfunction

    // driver: one operation, expected value pushed at issue time
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] exp_res, input int lat);
        int n;
        @(negedge clk);
        op1 = a; op2 = b; sub = s; ready = 1'b1;
        exp_q.push_back(exp_res);
        lat_q.push_back(lat);
        start_cyc = cyc;
        @(negedge clk);
        ready = 1'b0;
        n = 0;
        while ((done !== 1'b1) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            $display("FAIL done_timeout: no done within 300 cycles for %08h op %08h, expected %08h",
                     a, b, exp_res);
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (done) begin
                done_cnt <= done_cnt + 1;
                check("done_pulse_width", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: res %08h, required no done", res);
                end else begin
                    check("res", res, exp_q.pop_front());
                    if (lat_q.pop_front() == 3) check("special_latency", 32'(cyc - start_cyc), 32'd3);
                end
                held_res <= res;
            end else if (prev_done) begin
                check("res_hold", res, held_res);
            end
            prev_done <= done;
        end
    end

    logic [31:0] ta, tb;
    logic        ts;
    int          snap;
    logic [31:0] spec_vals[6];

    initial begin
        checks = 0; passes = 0; cyc = 0; start_cyc = 0; done_cnt = 0;
        rst = 1'b1; ready = 1'b0; sub = 1'b0; op1 = 32'd0; op2 = 32'd0;
        spec_vals = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                      32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001};
        repeat (3) @(negedge clk);
        check("reset_res", res, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // directed cases with hand-derived expectations
        run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 0);
        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 3);
        run_op(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 0);
        run_op(32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, 0);
        run_op(32'h3F80_0000, 32'h4B80_0000, 1'b0, 32'h4B80_0000, 0);
        run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 0);
        run_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'hFFC0_0000, 3);
        run_op(32'h7FA0_0000, 32'h3F80_0000, 1'b0, 32'h7FE0_0000, 3);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 0);
        run_op(32'h007F_FFFF, 32'h0000_0001, 1'b0, 32'h0080_0000, 0);
        run_op(32'h0080_0000, 32'h007F_FFFF, 1'b1, 32'h0000_0001, 0);
        run_op(32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F7F_FFFF, 0);
        run_op(32'h3F80_0000, 32'h2F80_0000, 1'b1, 32'h3F80_0000, 0);

        // reset mid-alignment: 2^23 + 1.0 needs 23 alignment shifts
        @(negedge clk);
        op1 = 32'h4B00_0000; op2 = 32'h3F80_0000; sub = 1'b0; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_res", res, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        snap = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(snap));
        run_op(32'h4040_0000, 32'hBF80_0000, 1'b0, 32'h4000_0000, 0);

        // randomized operands against the reference model
        for (int i = 0; i < 400; i++) begin
            int ex, eo;
            ta = $urandom; tb = $urandom; ts = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: ;
                1, 2, 3, 4: begin
                    ex = int'(ta[30:23]) % 255;
                    ta[30:23] = 8'(ex);
                    eo = ex + $urandom_range(0, 60) - 30;
                    if (eo < 0) eo = 0;
                    if (eo > 254) eo = 254;
                    tb[30:23] = 8'(eo);
                end
                5: begin
                    ta[30:23] = 8'd0;
                    tb[30:23] = 8'($urandom_range(0, 1));
                end
                6: begin
                    ta[30:23] = 8'($urandom_range(1, 254));
                    tb = ta;
                    tb[3:0] = 4'($urandom_range(0, 15));
                    tb[31] = ts ? ta[31] : ~ta[31];
                end
                7: begin
                    ta = spec_vals[$urandom_range(0, 5)];
                    if ($urandom_range(0, 1) == 1) tb = spec_vals[$urandom_range(0, 5)];
                end
                8: begin
                    ta[30:23] = 8'($urandom_range(60, 254));
                    tb[30:23] = ta[30:23] - 8'($urandom_range(24, 40));
                end
                default: begin
                    ta[30:23] = 8'($urandom_range(250, 254));
                    tb[30:23] = 8'($urandom_range(250, 254));
                end
            endcase
            run_op(ta, tb, ts, ref_add(ta, tb, ts),
                   (is_nan(ta) || is_nan(tb) || is_inf(ta) || is_inf(tb) ||
                    ((ta[30:0] == 31'd0) && (tb[30:0] == 31'd0))) ? 3 : 0);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL pending_results: %0d outstanding, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
